// File: rtl/seq_detector_param_if.sv
// Control/data bundle for seq_detector_param.
//   master: drives en, x, load, pattern_in, len_in, overlap, clr_count;
//           observes z, match_count, cur_len.
//   slave : the detector side of the same signals.
interface seq_detector_param_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CNT_W   = 8
);
  logic               en;
  logic               x;
  logic               load;
  logic [MAX_LEN-1:0] pattern_in;
  logic [LEN_W-1:0]   len_in;
  logic               overlap;
  logic               clr_count;
  logic               z;
  logic [CNT_W-1:0]   match_count;
  logic [LEN_W-1:0]   cur_len;

  modport master (
    output en, x, load, pattern_in, len_in, overlap, clr_count,
    input  z, match_count, cur_len
  );

  modport slave (
    input  en, x, load, pattern_in, len_in, overlap, clr_count,
    output z, match_count, cur_len
  );
endinterface

// File: rtl/seq_detector_param.sv
// Programmable serial pattern detector.
// Samples x on every enabled edge and flags (z, one cycle, registered) when the
// newest len bits equal pattern[len-1:0]. Supports overlapping and
// non-overlapping detection and keeps a saturating match counter.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; restores RESET_PAT/RESET_LEN
//   bus.slave  en, x, load, pattern_in, len_in, overlap, clr_count (in)
//              z, match_count, cur_len (out, all registered)
module seq_detector_param #(
  parameter int unsigned        MAX_LEN   = 8,
  parameter int unsigned        LEN_W     = 4,
  parameter int unsigned        CNT_W     = 8,
  parameter logic [MAX_LEN-1:0] RESET_PAT = MAX_LEN'(8'b0000_1011),
  parameter int unsigned        RESET_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_detector_param_if.slave  bus
);

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic               z_q;
  logic [CNT_W-1:0]   count_q;

  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   len_clamp;
  logic               match_c;
  logic               cnt_full;

  // Next history/fill, active-length mask, match decision and clamped load length.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end

    hist_n = {hist_q[MAX_LEN-2:0], bus.x};
    fill_n = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);

    // Bits above len are masked out so they never affect the compare.
    match_c = (fill_n >= len_q) && (((hist_n ^ pattern_q) & len_mask) == '0);

    if (bus.len_in == '0) begin
      len_clamp = LEN_W'(1);
    end else if (bus.len_in > LEN_W'(MAX_LEN)) begin
      len_clamp = LEN_W'(MAX_LEN);
    end else begin
      len_clamp = bus.len_in;
    end

    cnt_full = &count_q;
  end

  // Detector state; load restarts detection, clr_count wins over an increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q <= RESET_PAT;
      len_q     <= LEN_W'(RESET_LEN);
      hist_q    <= '0;
      fill_q    <= '0;
      z_q       <= 1'b0;
      count_q   <= '0;
    end else begin
      z_q <= 1'b0;
      if (bus.load) begin
        pattern_q <= bus.pattern_in;
        len_q     <= len_clamp;
        hist_q    <= '0;
        fill_q    <= '0;
      end else if (bus.en) begin
        hist_q <= hist_n;
        if (match_c) begin
          z_q <= 1'b1;
          // Non-overlapping mode discards the bits that formed this match.
          fill_q <= bus.overlap ? fill_n : '0;
          if (!cnt_full) begin
            count_q <= count_q + CNT_W'(1);
          end
        end else begin
          fill_q <= fill_n;
        end
      end
      if (bus.clr_count) begin
        count_q <= '0;
      end
    end
  end

  assign bus.z           = z_q;
  assign bus.match_count = count_q;
  assign bus.cur_len     = len_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: two instances (CNT_W=8 and
// CNT_W=2) receive identical stimulus and are compared against a queue-based
// reference model of the detection rules.
module tb_seq_detector_param;

  logic clk;
  logic reset;

  seq_detector_param_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) ifa ();
  seq_detector_param_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) ifb ();

  seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: bits received since the last restart, newest at the back.
  bit         m_bits[$];
  logic [7:0] m_pat;
  int         m_len;
  int         m_c8;
  int         m_c2;
  bit         m_z;
  bit         ov_mode;

  function automatic void model_reset();
    m_bits.delete();
    m_pat = 8'b0000_1011;
    m_len = 4;
    m_c8  = 0;
    m_c2  = 0;
    m_z   = 1'b0;
  endfunction

  function automatic void model_edge(bit e, bit xb, bit ld, logic [7:0] p, int l, bit clr);
    bit hit;
    m_z = 1'b0;
    if (ld) begin
      m_pat = p;
      m_len = (l == 0) ? 1 : ((l > 8) ? 8 : l);
      m_bits.delete();
    end else if (e) begin
      m_bits.push_back(xb);
      if (m_bits.size() > 8) void'(m_bits.pop_front());
      if (m_bits.size() >= m_len) begin
        hit = 1'b1;
        for (int i = 0; i < m_len; i++) begin
          if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) hit = 1'b0;
        end
        if (hit) begin
          m_z = 1'b1;
          if (m_c8 < 255) m_c8++;
          if (m_c2 < 3) m_c2++;
          if (!ov_mode) m_bits.delete();
        end
      end
    end
    if (clr) begin
      m_c8 = 0;
      m_c2 = 0;
    end
  endfunction

  // Drive one edge's inputs to both instances, clock, update the model, settle.
  task automatic step(input bit e, input bit xb, input bit ld, input logic [7:0] p,
                      input logic [3:0] l, input bit clr);
    ifa.en = e;  ifa.x = xb;  ifa.load = ld;  ifa.pattern_in = p;  ifa.len_in = l;
    ifa.overlap = ov_mode;  ifa.clr_count = clr;
    ifb.en = e;  ifb.x = xb;  ifb.load = ld;  ifb.pattern_in = p;  ifb.len_in = l;
    ifb.overlap = ov_mode;  ifb.clr_count = clr;
    @(posedge clk);
    model_edge(e, xb, ld, p, int'(l), clr);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    total++;
    if (ifa.z !== 1'b0 || ifb.z !== 1'b0) begin
      bad++; $display("FAIL reset_z got=%0b/%0b want=0", ifa.z, ifb.z);
    end
    total++;
    if (ifa.match_count !== 8'd0 || ifb.match_count !== 2'd0) begin
      bad++; $display("FAIL reset_cnt got=%0d/%0d want=0", ifa.match_count, ifb.match_count);
    end
    total++;
    if (ifa.cur_len !== 4'd4) begin
      bad++; $display("FAIL reset_len got=%0d want=4", ifa.cur_len);
    end
    reset = 1'b0;
  endtask

  task automatic test_default_overlap();
    bit xs[7] = '{1, 0, 1, 1, 0, 1, 1};
    bit zs[7] = '{0, 0, 0, 1, 0, 0, 1};
    do_reset();
    ov_mode = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, xs[i], 1'b0, 8'h00, 4'd0, 1'b0);
      total++;
      if (ifa.z !== zs[i]) begin
        bad++; $display("FAIL ovl_z bit%0d got=%0b want=%0b", i + 1, ifa.z, zs[i]);
      end
    end
    total++;
    if (ifa.match_count !== 8'd2) begin
      bad++; $display("FAIL ovl_cnt got=%0d want=2", ifa.match_count);
    end
  endtask

  task automatic test_nonoverlap();
    bit xs[7]  = '{1, 0, 1, 1, 0, 1, 1};
    bit zs[7]  = '{0, 0, 0, 1, 0, 0, 0};
    bit xs2[8] = '{1, 0, 1, 1, 1, 0, 1, 1};
    bit zs2[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    do_reset();
    ov_mode = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, xs[i], 1'b0, 8'h00, 4'd0, 1'b0);
      total++;
      if (ifa.z !== zs[i]) begin
        bad++; $display("FAIL novl_z bit%0d got=%0b want=%0b", i + 1, ifa.z, zs[i]);
      end
    end
    total++;
    if (ifa.match_count !== 8'd1) begin
      bad++; $display("FAIL novl_cnt got=%0d want=1", ifa.match_count);
    end
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, xs2[i], 1'b0, 8'h00, 4'd0, 1'b0);
      total++;
      if (ifa.z !== zs2[i]) begin
        bad++; $display("FAIL novl2_z bit%0d got=%0b want=%0b", i + 1, ifa.z, zs2[i]);
      end
    end
  endtask

  task automatic test_load();
    bit xs[6] = '{1, 1, 0, 1, 1, 0};
    bit zs[6] = '{0, 0, 1, 0, 0, 1};
    do_reset();
    ov_mode = 1'b1;
    step(1'b1, 1'b1, 1'b1, 8'b0000_0110, 4'd3, 1'b0);
    total++;
    if (ifa.cur_len !== 4'd3 || ifa.z !== 1'b0) begin
      bad++; $display("FAIL load3 len=%0d z=%0b want len=3 z=0", ifa.cur_len, ifa.z);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, xs[i], 1'b0, 8'h00, 4'd0, 1'b0);
      total++;
      if (ifa.z !== zs[i]) begin
        bad++; $display("FAIL load3_z bit%0d got=%0b want=%0b", i + 1, ifa.z, zs[i]);
      end
    end
    step(1'b1, 1'b0, 1'b1, 8'b1111_0001, 4'd0, 1'b0);
    total++;
    if (ifa.cur_len !== 4'd1 || ifa.match_count !== 8'd2) begin
      bad++; $display("FAIL load0 len=%0d cnt=%0d want len=1 cnt=2", ifa.cur_len, ifa.match_count);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
      total++;
      if (ifa.z !== 1'b1) begin
        bad++; $display("FAIL len1_z bit%0d got=%0b want=1", i + 1, ifa.z);
      end
    end
    step(1'b1, 1'b0, 1'b1, 8'h00, 4'd15, 1'b0);
    total++;
    if (ifa.cur_len !== 4'd8) begin
      bad++; $display("FAIL load15 len got=%0d want=8", ifa.cur_len);
    end
  endtask

  task automatic test_stall();
    bit xs[3] = '{1, 0, 1};
    do_reset();
    ov_mode = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, xs[i], 1'b0, 8'h00, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
      total++;
      if (ifa.z !== 1'b0) begin
        bad++; $display("FAIL stall_z cyc%0d got=%0b want=0", i, ifa.z);
      end
    end
    step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
    total++;
    if (ifa.z !== 1'b1) begin
      bad++; $display("FAIL stall_hit got=%0b want=1", ifa.z);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
    total++;
    if (ifa.z !== 1'b0 || ifa.match_count !== 8'd1) begin
      bad++; $display("FAIL stall_after z=%0b cnt=%0d want z=0 cnt=1", ifa.z, ifa.match_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    ov_mode = 1'b1;
    step(1'b1, 1'b0, 1'b1, 8'b0000_0011, 4'd2, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
    total++;
    if (ifb.match_count !== 2'd3) begin
      bad++; $display("FAIL sat_cnt2 got=%0d want=3", ifb.match_count);
    end
    total++;
    if (ifa.match_count !== 8'd5) begin
      bad++; $display("FAIL sat_cnt8 got=%0d want=5", ifa.match_count);
    end
    step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1);
    total++;
    if (ifb.match_count !== 2'd0 || ifa.match_count !== 8'd0 || ifb.z !== 1'b1) begin
      bad++; $display("FAIL clr_hit cnt=%0d/%0d z=%0b want cnt=0/0 z=1",
                      ifa.match_count, ifb.match_count, ifb.z);
    end
  endtask

  task automatic test_async_reset();
    bit xs[4] = '{1, 0, 1, 1};
    do_reset();
    ov_mode = 1'b1;
    step(1'b1, 1'b0, 1'b1, 8'b0000_0110, 4'd3, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    total++;
    if (ifa.z !== 1'b1 || ifa.cur_len !== 4'd3) begin
      bad++; $display("FAIL pre_rst z=%0b len=%0d want z=1 len=3", ifa.z, ifa.cur_len);
    end
    #2 reset = 1'b1;
    #1;
    model_reset();
    total++;
    if (ifa.z !== 1'b0 || ifa.match_count !== 8'd0 || ifa.cur_len !== 4'd4) begin
      bad++; $display("FAIL async_rst z=%0b cnt=%0d len=%0d want 0/0/4",
                      ifa.z, ifa.match_count, ifa.cur_len);
    end
    // Pattern bits presented while reset is held must not produce z.
    ifa.en = 1'b1; ifa.x = 1'b1; ifb.en = 1'b1; ifb.x = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (ifa.z !== 1'b0) begin
      bad++; $display("FAIL rst_held_z got=%0b want=0", ifa.z);
    end
    #3 reset = 1'b0;
    step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
    total++;
    if (ifa.z !== 1'b0) begin
      bad++; $display("FAIL post_rst_single got=%0b want=0", ifa.z);
    end
    for (int i = 0; i < 4; i++) step(1'b1, xs[i], 1'b0, 8'h00, 4'd0, 1'b0);
    total++;
    if (ifa.z !== 1'b1 || ifa.match_count !== 8'd1) begin
      bad++; $display("FAIL post_rst_hit z=%0b cnt=%0d want z=1 cnt=1", ifa.z, ifa.match_count);
    end
  endtask

  task automatic test_random();
    bit         e, xb, ld, clr;
    logic [7:0] p;
    logic [3:0] l;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      ov_mode = ($urandom_range(0, 9) < 6);
      e   = ($urandom_range(0, 9) < 8);
      xb  = 1'($urandom_range(0, 1));
      ld  = ($urandom_range(0, 49) == 0);
      clr = ($urandom_range(0, 59) == 0);
      p   = 8'($urandom);
      l   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      step(e, xb, ld, p, l, clr);
      total++;
      if (ifa.z !== m_z || ifb.z !== m_z) begin
        bad++; $display("FAIL rnd_z n=%0d got=%0b/%0b want=%0b", n, ifa.z, ifb.z, m_z);
      end
      total++;
      if (ifa.match_count !== 8'(m_c8) || ifb.match_count !== 2'(m_c2)) begin
        bad++; $display("FAIL rnd_cnt n=%0d got=%0d/%0d want=%0d/%0d",
                        n, ifa.match_count, ifb.match_count, m_c8, m_c2);
      end
      total++;
      if (ifa.cur_len !== 4'(m_len)) begin
        bad++; $display("FAIL rnd_len n=%0d got=%0d want=%0d", n, ifa.cur_len, m_len);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    ov_mode = 1'b1;
    ifa.en = 1'b0; ifa.x = 1'b0; ifa.load = 1'b0; ifa.pattern_in = '0; ifa.len_in = '0;
    ifa.overlap = 1'b1; ifa.clr_count = 1'b0;
    ifb.en = 1'b0; ifb.x = 1'b0; ifb.load = 1'b0; ifb.pattern_in = '0; ifb.len_in = '0;
    ifb.overlap = 1'b1; ifb.clr_count = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_default_overlap();
    test_nonoverlap();
    test_load();
    test_stall();
    test_saturation();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
